envelope_sequencer: RTL and testbench



---
 rtl/envelope_sequencer_pkg.sv | 31 +++
 rtl/envelope_sequencer_tick_prescaler.sv | 31 +++
 rtl/envelope_sequencer.sv | 118 +++++++++++
 tb/tb_envelope_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/envelope_sequencer_pkg.sv
// Shared envelope definitions: segment record, segment count, trigger bit and sequencer states.
`ifndef ENVELOPE_LEN
`define ENVELOPE_LEN 4
`endif
`ifndef ENVELOPE_RESET_BIT
`define ENVELOPE_RESET_BIT 0
`endif

package envelope_sequencer_pkg;

  localparam int ENV_GAIN_W    = 8;
  localparam int ENV_DUR_W     = 8;
  localparam int ENV_RESET_BIT = `ENVELOPE_RESET_BIT;

  typedef struct packed {
    logic [ENV_GAIN_W-1:0] gain;
    logic [ENV_DUR_W-1:0]  duration;
  } envelope_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } env_state_t;

  // Counter width that stays legal for a count of one.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/envelope_sequencer_tick_prescaler.sv
// Divides the sample-rate strobe down to one duration-unit tick every DUR_SCALE strobes.
module tick_prescaler
  import envelope_sequencer_pkg::*;
#(
  parameter  int DUR_SCALE = 48,
  localparam int PW        = cnt_w(DUR_SCALE)
) (
  input  logic clk,
  input  logic rstn,
  input  logic sample_en,
  input  logic clear,
  output logic unit_tick
);

  localparam logic [PW-1:0] LAST = PW'(DUR_SCALE - 1);

  logic [PW-1:0] prescaler;

  assign unit_tick = sample_en & (prescaler == LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prescaler <= '0;
    end else if (clear) begin
      prescaler <= '0;
    end else if (sample_en) begin
      prescaler <= unit_tick ? '0 : prescaler + 1'b1;
    end
  end

endmodule

// File: rtl/envelope_sequencer.sv
// Per-oscillator envelope: walks gain/duration segments at the sample rate and scales velocity by gain.
module envelope_sequencer
  import envelope_sequencer_pkg::*;
#(
  parameter  int ENV_LEN   = `ENVELOPE_LEN,
  parameter  int DUR_SCALE = 48,
  parameter  int GAIN_W    = ENV_GAIN_W,
  parameter  int DUR_W     = ENV_DUR_W,
  parameter  int VEL_W     = 32,
  localparam int IDX_W     = cnt_w(ENV_LEN)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              sample_en,
  input  envelope_t         envelopes [ENV_LEN],
  input  logic [7:0]        cmds,
  input  logic [VEL_W-1:0]  velocity,
  output logic [GAIN_W-1:0] gain_out,
  output logic [VEL_W-1:0]  amp_out,
  output logic [IDX_W-1:0]  seg_idx,
  output logic              active,
  output logic              done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENV_LEN - 1);

  env_state_t       state;
  logic             trig_q;
  logic             trig;
  logic             tick_en;
  logic             unit_tick;
  logic             adv;
  logic             last_seg;
  logic [DUR_W-1:0] seg_dur;
  logic [DUR_W-1:0] dur_cnt;
  logic [IDX_W-1:0] nxt_idx;
  envelope_t        first_env;
  envelope_t        nxt_env;

  function automatic logic [VEL_W-1:0] scale_amp(input logic [VEL_W-1:0]  vel,
                                                 input logic [GAIN_W-1:0] g);
    logic [VEL_W+GAIN_W-1:0] prod;
    prod = {{GAIN_W{1'b0}}, vel} * {{VEL_W{1'b0}}, g};
    return prod[VEL_W+GAIN_W-1:GAIN_W];
  endfunction

  // The control unit holds the trigger bit for a whole sample period, so only its rising edge counts.
  assign trig      = cmds[ENV_RESET_BIT] & ~trig_q;
  assign tick_en   = sample_en & (state == RUN);
  assign adv       = ~trig & unit_tick & (dur_cnt == seg_dur - 1'b1);
  assign last_seg  = (seg_idx == LAST_IDX);
  assign nxt_idx   = seg_idx + 1'b1;
  assign first_env = envelopes[0];
  assign nxt_env   = envelopes[nxt_idx];

  tick_prescaler #(
    .DUR_SCALE (DUR_SCALE)
  ) u_tick_prescaler (
    .clk       (clk),
    .rstn      (rstn),
    .sample_en (tick_en),
    .clear     (trig | adv),
    .unit_tick (unit_tick)
  );

  // Stage p0: segment sequencing; envelope data is sampled only on segment entry.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      trig_q   <= 1'b0;
      seg_idx  <= '0;
      seg_dur  <= '0;
      dur_cnt  <= '0;
      gain_out <= '0;
      active   <= 1'b0;
      done     <= 1'b0;
    end else begin
      trig_q <= cmds[ENV_RESET_BIT];
      done   <= 1'b0;
      if (trig) begin
        seg_idx  <= '0;
        seg_dur  <= first_env.duration;
        dur_cnt  <= '0;
        gain_out <= first_env.gain;
        state    <= (first_env.duration == '0) ? HOLD : RUN;
        active   <= 1'b1;
      end else if (unit_tick) begin
        if (adv) begin
          dur_cnt <= '0;
          if (last_seg) begin
            state    <= IDLE;
            seg_idx  <= '0;
            gain_out <= '0;
            active   <= 1'b0;
            done     <= 1'b1;
          end else begin
            seg_idx  <= nxt_idx;
            seg_dur  <= nxt_env.duration;
            gain_out <= nxt_env.gain;
            state    <= (nxt_env.duration == '0) ? HOLD : RUN;
          end
        end else begin
          dur_cnt <= dur_cnt + 1'b1;
        end
      end
    end
  end

  // Stage p1: amplitude follows gain by one clock, using the live velocity.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      amp_out <= '0;
    end else begin
      amp_out <= scale_amp(velocity, gain_out);
    end
  end

endmodule

// File: tb/tb_envelope_sequencer.sv
// Directed bench for envelope_sequencer with DUR_SCALE=2 and four segments.
module tb_envelope_sequencer;
  import envelope_sequencer_pkg::*;

  logic        clk;
  logic        rstn;
  logic        sample_en;
  envelope_t   envelopes [4];
  logic [7:0]  cmds;
  logic [31:0] velocity;
  logic [7:0]  gain_out;
  logic [31:0] amp_out;
  logic [1:0]  seg_idx;
  logic        active;
  logic        done;

  int errors;
  int checks;
  int done_cnt;

  envelope_sequencer #(
    .ENV_LEN   (4),
    .DUR_SCALE (2),
    .GAIN_W    (8),
    .DUR_W     (8),
    .VEL_W     (32)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .sample_en (sample_en),
    .envelopes (envelopes),
    .cmds      (cmds),
    .velocity  (velocity),
    .gain_out  (gain_out),
    .amp_out   (amp_out),
    .seg_idx   (seg_idx),
    .active    (active),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic se);
    sample_en = se;
    @(negedge clk);
    sample_en = 1'b0;
    if (done === 1'b1) done_cnt++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1);
  endtask

  task automatic trigger();
    cmds[ENV_RESET_BIT] = 1'b1;
    step(1'b0);
    cmds[ENV_RESET_BIT] = 1'b0;
  endtask

  task automatic set_basic();
    envelopes[0] = {8'd200, 8'd1};
    envelopes[1] = {8'd100, 8'd2};
    envelopes[2] = {8'd50,  8'd1};
    envelopes[3] = {8'd10,  8'd1};
    velocity     = 32'h100;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (gain_out !== 8'd0) begin errors++; $display("FAIL rst_gain: got %0d expected 0", gain_out); end
    checks++; if (amp_out !== 32'd0) begin errors++; $display("FAIL rst_amp: got %0h expected 0", amp_out); end
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL rst_active: got %0b expected 0", active); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %0b expected 0", done); end
    checks++; if (seg_idx !== 2'd0) begin errors++; $display("FAIL rst_seg: got %0d expected 0", seg_idx); end
    rstn = 1'b1;
    @(negedge clk);
    done_cnt = 0;
    ticks(20);
    checks++; if (gain_out !== 8'd0) begin errors++; $display("FAIL idle_gain: got %0d expected 0", gain_out); end
    checks++; if (amp_out !== 32'd0) begin errors++; $display("FAIL idle_amp: got %0h expected 0", amp_out); end
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL idle_active: got %0b expected 0", active); end
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL idle_done: got %0d pulses expected 0", done_cnt); end
  endtask

  task automatic test_basic_sequence();
    set_basic();
    step(1'b0);
    done_cnt = 0;
    trigger();
    checks++; if (gain_out !== 8'd200) begin errors++; $display("FAIL seq_trig_gain: got %0d expected 200", gain_out); end
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL seq_active: got %0b expected 1", active); end
    step(1'b0);
    checks++; if (amp_out !== 32'd200) begin errors++; $display("FAIL seq_amp: got %0d expected 200", amp_out); end
    ticks(1);
    checks++; if (gain_out !== 8'd200) begin errors++; $display("FAIL seq0_hold: got %0d expected 200", gain_out); end
    ticks(1);
    checks++; if (gain_out !== 8'd100) begin errors++; $display("FAIL seq1_gain: got %0d expected 100", gain_out); end
    checks++; if (seg_idx !== 2'd1) begin errors++; $display("FAIL seq1_idx: got %0d expected 1", seg_idx); end
    ticks(3);
    checks++; if (gain_out !== 8'd100) begin errors++; $display("FAIL seq1_hold: got %0d expected 100", gain_out); end
    ticks(1);
    checks++; if (gain_out !== 8'd50) begin errors++; $display("FAIL seq2_gain: got %0d expected 50", gain_out); end
    ticks(2);
    checks++; if (gain_out !== 8'd10) begin errors++; $display("FAIL seq3_gain: got %0d expected 10", gain_out); end
    ticks(1);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL seq_done_early: got %0b expected 0", done); end
    ticks(1);
    checks++; if (gain_out !== 8'd0) begin errors++; $display("FAIL seq_end_gain: got %0d expected 0", gain_out); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL seq_done: got %0b expected 1", done); end
    checks++; if (seg_idx !== 2'd0) begin errors++; $display("FAIL seq_end_idx: got %0d expected 0", seg_idx); end
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL seq_end_active: got %0b expected 0", active); end
    step(1'b0);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL seq_done_width: got %0b expected 0", done); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL seq_done_count: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_sustain();
    set_basic();
    envelopes[1] = {8'd100, 8'd0};
    trigger();
    ticks(2);
    checks++; if (gain_out !== 8'd100) begin errors++; $display("FAIL hold_gain: got %0d expected 100", gain_out); end
    ticks(100);
    checks++; if (gain_out !== 8'd100) begin errors++; $display("FAIL hold_after100: got %0d expected 100", gain_out); end
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL hold_active: got %0b expected 1", active); end
    checks++; if (seg_idx !== 2'd1) begin errors++; $display("FAIL hold_idx: got %0d expected 1", seg_idx); end
    step(1'b0);
    trigger();
    checks++; if (gain_out !== 8'd200) begin errors++; $display("FAIL hold_retrig_gain: got %0d expected 200", gain_out); end
    checks++; if (seg_idx !== 2'd0) begin errors++; $display("FAIL hold_retrig_idx: got %0d expected 0", seg_idx); end
  endtask

  task automatic test_retrigger_priority();
    set_basic();
    step(1'b0);
    trigger();
    ticks(6);
    checks++; if (gain_out !== 8'd50) begin errors++; $display("FAIL rt_seg2: got %0d expected 50", gain_out); end
    ticks(1);
    trigger();
    checks++; if (gain_out !== 8'd200) begin errors++; $display("FAIL rt_gain: got %0d expected 200", gain_out); end
    checks++; if (seg_idx !== 2'd0) begin errors++; $display("FAIL rt_idx: got %0d expected 0", seg_idx); end
    ticks(1);
    checks++; if (gain_out !== 8'd200) begin errors++; $display("FAIL rt_full_seg0: got %0d expected 200", gain_out); end
    ticks(1);
    checks++; if (gain_out !== 8'd100) begin errors++; $display("FAIL rt_seg1: got %0d expected 100", gain_out); end
    ticks(6);
    checks++; if (gain_out !== 8'd10) begin errors++; $display("FAIL rt_seg3: got %0d expected 10", gain_out); end
    ticks(1);
    done_cnt = 0;
    cmds[ENV_RESET_BIT] = 1'b1;
    step(1'b1);
    cmds[ENV_RESET_BIT] = 1'b0;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL prio_done: got %0b expected 0", done); end
    checks++; if (gain_out !== 8'd200) begin errors++; $display("FAIL prio_gain: got %0d expected 200", gain_out); end
    checks++; if (seg_idx !== 2'd0) begin errors++; $display("FAIL prio_idx: got %0d expected 0", seg_idx); end
    step(1'b0);
    ticks(1);
    checks++; if (gain_out !== 8'd200) begin errors++; $display("FAIL prio_tick_dropped: got %0d expected 200", gain_out); end
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL prio_done_count: got %0d expected 0", done_cnt); end
  endtask

  task automatic test_latching();
    set_basic();
    step(1'b0);
    trigger();
    ticks(2);
    checks++; if (gain_out !== 8'd100) begin errors++; $display("FAIL latch_seg1: got %0d expected 100", gain_out); end
    envelopes[1].gain = 8'd77;
    ticks(3);
    checks++; if (gain_out !== 8'd100) begin errors++; $display("FAIL latch_no_glitch: got %0d expected 100", gain_out); end
    envelopes[2] = {8'd33, 8'd1};
    ticks(1);
    checks++; if (gain_out !== 8'd33) begin errors++; $display("FAIL latch_new_seg2: got %0d expected 33", gain_out); end
    ticks(2);
    checks++; if (gain_out !== 8'd10) begin errors++; $display("FAIL latch_seg3: got %0d expected 10", gain_out); end
  endtask

  task automatic test_arith_async_reset();
    set_basic();
    velocity     = 32'hFFFF_FFFF;
    envelopes[0] = {8'd255, 8'd1};
    step(1'b0);
    trigger();
    checks++; if (gain_out !== 8'd255) begin errors++; $display("FAIL arith_gain: got %0d expected 255", gain_out); end
    step(1'b0);
    checks++; if (amp_out !== 32'hFEFF_FFFF) begin errors++; $display("FAIL arith_amp: got %0h expected feffffff", amp_out); end
    ticks(1);
    #1 rstn = 1'b0;
    #1;
    checks++; if (gain_out !== 8'd0) begin errors++; $display("FAIL async_gain: got %0d expected 0", gain_out); end
    checks++; if (amp_out !== 32'd0) begin errors++; $display("FAIL async_amp: got %0h expected 0", amp_out); end
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL async_active: got %0b expected 0", active); end
    checks++; if (seg_idx !== 2'd0) begin errors++; $display("FAIL async_idx: got %0d expected 0", seg_idx); end
    @(negedge clk);
    rstn = 1'b1;
    ticks(4);
    checks++; if (gain_out !== 8'd0) begin errors++; $display("FAIL post_rst_gain: got %0d expected 0", gain_out); end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    done_cnt  = 0;
    rstn      = 1'b0;
    sample_en = 1'b0;
    cmds      = 8'd0;
    velocity  = 32'd0;
    for (int i = 0; i < 4; i++) envelopes[i] = '0;
    test_reset();
    test_basic_sequence();
    test_sustain();
    test_retrigger_priority();
    test_latching();
    test_arith_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
